alu_lane_sequencer: RTL and testbench
=====================================

ALU_LANE_SEQUENCER -- requirements
Module: alu_lane_sequencer

Interface
REQ-001 Parameter BITS, default 8, lane width in bits.
REQ-002 Parameter ALUOP, default 4, ALU function-code width.
REQ-003 Parameter LANES, default 4, lanes per command (range 2..16).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 cmdValid  input  1  command offered.
REQ-007 cmdReady  output  1  sequencer can accept a command.
REQ-008 cmdOp  input  ALUOP  ALU function code for all lanes.
REQ-009 cmdA  input  LANES*BITS  packed operand A; lane i at bits [i*BITS +: BITS].
REQ-010 cmdB  input  LANES*BITS  packed operand B; same packing.
REQ-011 resValid  output  1  result available.
REQ-012 resReady  input  1  consumer accepts result.
REQ-013 resData  output  LANES*BITS  packed result; same packing.
REQ-014 resErr  output  1  command carried an unsupported function code.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 aluFunction  output  ALUOP  function code driven to the shared ALU.
REQ-017 aluOpA  output  BITS  ALU operand A (current lane).
REQ-018 aluOpB  output  BITS  ALU operand B (current lane).
REQ-019 aluResult  input  BITS  combinational ALU result for the driven operands.

Function
REQ-020 FSM states IDLE, RUN, DONE; cmdReady = 1 only in IDLE.
REQ-021 Command accepted on an edge where cmdValid && cmdReady; cmdOp, cmdA, cmdB latched; lane counter cleared to 0.
REQ-022 Legal codes 1..10: IDLE -> RUN on accept; codes 0 and 11..15: IDLE -> DONE directly, resData = 0, resErr = 1, no ALU access.
REQ-023 In RUN, aluFunction = latched op; aluOpA/aluOpB = latched lane[counter] of A/B; each edge writes aluResult into result lane[counter] and increments counter.
REQ-024 On the edge writing lane LANES-1, RUN -> DONE; counter does not wrap past LANES-1.
REQ-025 Outside RUN, aluFunction = 0, aluOpA = 0, aluOpB = 0.
REQ-026 Latency, legal op: resValid rises LANES edges after the accept edge; illegal op: 1 edge.
REQ-027 In DONE, resValid = 1; resData and resErr held stable until the edge where resReady = 1, then -> IDLE, resValid = 0.
REQ-028 resErr cleared on every accept of a legal command.
REQ-029 resReady ignored outside DONE; cmdValid ignored outside IDLE (no queueing).
REQ-030 Result lanes not yet written during RUN are not visible: resData only meaningful while resValid = 1.
REQ-031 All arithmetic is performed by the external ALU; sequencer performs no operand modification or width extension.

Reset
REQ-032 rst_n low forces state IDLE, counter 0, result and latched operands 0, resValid 0, resErr 0, busy 0, cmdReady 1, independent of clk.
REQ-033 Reset asserted mid-RUN or in DONE discards the command in flight; no partial result is ever presented.
REQ-034 First accept possible on the first rising edge after rst_n deasserts.

Configuration
REQ-035 Macro ALU_SEQ_ZERO_FLAG_EN defined: output resZero (1 bit) added, = 1 when all LANES*BITS bits of result are 0, registered alongside resData, valid with resValid, reset 0.
REQ-036 Macro ALU_SEQ_ZERO_FLAG_EN undefined: resZero port and its logic absent; all other behaviour identical.

Verification (BITS=8, ALUOP=4, LANES=4)
REQ-037 Add: cmdOp=2, cmdA=0x04030201, cmdB=0x10101010 -> resValid 4 edges after accept, resData=0x14131211, resErr=0.
REQ-038 Subtract wrap: cmdOp=3, cmdA=0x00000000, cmdB=0x00000001 -> resData=0x000000FF; aluFunction=3 for exactly 4 cycles, 0 otherwise.
REQ-039 Illegal op: cmdOp=11 -> resValid 1 edge after accept, resData=0, resErr=1, aluFunction stays 0 throughout.
REQ-040 Backpressure: resReady=0 for 10 cycles with cmdValid=1 -> resValid/resData stable, cmdReady=0, no second accept; resReady=1 -> IDLE next edge, second command accepted on the following edge.
REQ-041 Reset mid-RUN: rst_n low after lane 1 written -> all outputs reset values immediately; after release new cmdOp=5, cmdA=0xFF00FF00, cmdB=0x0F0F0F0F -> resData=0x0F000F00.
REQ-042 With ALU_SEQ_ZERO_FLAG_EN: cmdOp=4, cmdA=cmdB=0xA5A5A5A5 -> resData=0, resZero=1; cmdOp=2 same operands -> resData=0x4A4A4A4A, resZero=0.

Source files
------------

// File: rtl/alu_lane_sequencer_if.sv
// alu_lane_sequencer_if: command/result handshake plus the shared-ALU port bundle.
//   master : command source, result sink and owner of the combinational ALU
//   slave  : the sequencer
//   cmd*   : command offer (valid/ready, op, packed A/B)
//   res*   : result handshake (valid/ready, packed data, error flag)
//   alu*   : function/operands driven to the ALU, combinational result back
// ALU_SEQ_ZERO_FLAG_EN adds resZero (all-zero result flag).
interface alu_lane_sequencer_if #(
  parameter int BITS  = 8,
  parameter int ALUOP = 4,
  parameter int LANES = 4
);
  logic                    cmdValid;
  logic                    cmdReady;
  logic [ALUOP-1:0]        cmdOp;
  logic [LANES*BITS-1:0]   cmdA;
  logic [LANES*BITS-1:0]   cmdB;
  logic                    resValid;
  logic                    resReady;
  logic [LANES*BITS-1:0]   resData;
  logic                    resErr;
  logic                    busy;
  logic [ALUOP-1:0]        aluFunction;
  logic [BITS-1:0]         aluOpA;
  logic [BITS-1:0]         aluOpB;
  logic [BITS-1:0]         aluResult;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic                    resZero;
`endif

  modport master (
    output cmdValid, cmdOp, cmdA, cmdB, resReady, aluResult,
    input  cmdReady, resValid, resData, resErr, busy, aluFunction, aluOpA, aluOpB
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , input resZero
`endif
  );

  modport slave (
    input  cmdValid, cmdOp, cmdA, cmdB, resReady, aluResult,
    output cmdReady, resValid, resData, resErr, busy, aluFunction, aluOpA, aluOpB
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , output resZero
`endif
  );
endinterface

// File: rtl/alu_lane_sequencer.sv
// alu_lane_sequencer: applies one ALU function code to LANES operand lanes,
// one lane per clock through a shared external combinational ALU.
//   clk, rst_n : single clock, asynchronous active-low reset
//   bus        : alu_lane_sequencer_if.slave (command, result, ALU signals)
// ALU_SEQ_ZERO_FLAG_EN adds the registered resZero flag.
module alu_lane_sequencer #(
  parameter int BITS  = 8,
  parameter int ALUOP = 4,
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_lane_sequencer_if.slave  bus
);
  localparam int W  = LANES * BITS;
  localparam int CW = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [W-1:0]     a_q, b_q, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             res_valid_q, res_err_q;
  logic [ALUOP-1:0] alu_fn_q;
  logic [BITS-1:0]  alu_a_q, alu_b_q;
  logic             op_legal, last_lane;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic             zero_q;
`endif

  assign op_legal  = (bus.cmdOp != '0) && (bus.cmdOp <= ALUOP'(10));
  assign last_lane = (cnt_q == CW'(LANES - 1));
  assign cnt_d     = cnt_q + CW'(1);

  // Result with the current lane replaced by the ALU output.
  always_comb begin
    res_d = res_q;
    res_d[cnt_q*BITS +: BITS] = bus.aluResult;
  end

  // ALU drive registers hold the lane for the current counter value, so the
  // next lane is preloaded on the same edge that advances the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      alu_fn_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.cmdValid) begin
            a_q   <= bus.cmdA;
            b_q   <= bus.cmdB;
            cnt_q <= '0;
            res_q <= '0;
            if (op_legal) begin
              state_q   <= RUN;
              res_err_q <= 1'b0;
              alu_fn_q  <= bus.cmdOp;
              alu_a_q   <= bus.cmdA[BITS-1:0];
              alu_b_q   <= bus.cmdB[BITS-1:0];
            end else begin
              state_q     <= DONE;
              res_valid_q <= 1'b1;
              res_err_q   <= 1'b1;
`ifdef ALU_SEQ_ZERO_FLAG_EN
              zero_q      <= 1'b1;
`endif
            end
          end
        end
        RUN: begin
          res_q <= res_d;
          if (last_lane) begin
            state_q     <= DONE;
            res_valid_q <= 1'b1;
            alu_fn_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero_q      <= (res_d == '0);
`endif
          end else begin
            cnt_q   <= cnt_d;
            alu_a_q <= a_q[cnt_d*BITS +: BITS];
            alu_b_q <= b_q[cnt_d*BITS +: BITS];
          end
        end
        DONE: begin
          if (bus.resReady) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero_q      <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmdReady    = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.resValid    = res_valid_q;
  // Partially written lanes never leave the block.
  assign bus.resData     = res_valid_q ? res_q : '0;
  assign bus.resErr      = res_err_q;
  assign bus.aluFunction = alu_fn_q;
  assign bus.aluOpA      = alu_a_q;
  assign bus.aluOpB      = alu_b_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  assign bus.resZero     = zero_q;
`endif
endmodule

// File: tb/tb_alu_lane_sequencer.sv
module tb_alu_lane_sequencer;
  localparam int BITS  = 8;
  localparam int ALUOP = 4;
  localparam int LANES = 4;
  localparam int NV    = 14;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_lane_sequencer_if #(.BITS(BITS), .ALUOP(ALUOP), .LANES(LANES)) bus ();

  alu_lane_sequencer #(.BITS(BITS), .ALUOP(ALUOP), .LANES(LANES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Bench-side ALU: 1 passA, 2 add, 3 sub, 4 xor, 5 and, 6 or, 7 passB,
  // 8 shl1 A, 9 shr1 A, 10 not A.
  function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd1:    return a;
      4'd2:    return a + b;
      4'd3:    return a - b;
      4'd4:    return a ^ b;
      4'd5:    return a & b;
      4'd6:    return a | b;
      4'd7:    return b;
      4'd8:    return a << 1;
      4'd9:    return a >> 1;
      4'd10:   return ~a;
      default: return 8'h00;
    endcase
  endfunction

  always_comb bus.aluResult = alu_ref(bus.aluFunction, bus.aluOpA, bus.aluOpB);

  function automatic logic is_legal(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd10);
  endfunction

  // Whole-command reference: every lane through the ALU, or zero on an illegal code.
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    if (is_legal(op))
      for (int i = 0; i < LANES; i++) r[i*8 +: 8] = alu_ref(op, a[i*8 +: 8], b[i*8 +: 8]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vecs [NV];

  // Presents one command, waits (bounded) for the result, optionally takes it.
  // lat counts edges after the accept edge; an illegal code reaches DONE on
  // the accept edge itself, so its lat is 0. lane_ok tracks the ALU drive.
  task automatic run_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic take,
                         output logic [31:0] data, output logic err, output logic zero,
                         output int lat, output int fn_cyc, output logic lane_ok);
    chk("cmdReady_before_offer", bus.cmdReady, 1);
    bus.cmdValid = 1'b1;
    bus.cmdOp    = op;
    bus.cmdA     = a;
    bus.cmdB     = b;
    bus.resReady = 1'b0;
    @(posedge clk); #1;
    bus.cmdValid = 1'b0;
    lat = 0; fn_cyc = 0; lane_ok = 1'b1;
    while (!bus.resValid && lat < 40) begin
      if (bus.aluFunction != '0) begin
        if (fn_cyc < LANES) begin
          if (bus.aluFunction !== op || bus.aluOpA !== a[fn_cyc*8 +: 8] || bus.aluOpB !== b[fn_cyc*8 +: 8])
            lane_ok = 1'b0;
        end
        fn_cyc++;
      end else if (bus.aluOpA !== 8'h00 || bus.aluOpB !== 8'h00) begin
        lane_ok = 1'b0;
      end
      @(posedge clk); #1; lat++;
    end
    if (bus.aluFunction != '0) fn_cyc++;
    data = bus.resData;
    err  = bus.resErr;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    zero = bus.resZero;
`else
    zero = (bus.resData == '0);
`endif
    if (take) begin
      bus.resReady = 1'b1;
      @(posedge clk); #1;
      bus.resReady = 1'b0;
    end
  endtask

  task automatic check_cmd(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] data;
    logic        err, zero, lane_ok;
    int          lat, fn_cyc;
    run_cmd(op, a, b, 1'b1, data, err, zero, lat, fn_cyc, lane_ok);
    chk({tag, "_resData"}, data, exp_data);
    chk({tag, "_resErr"}, err, exp_err);
    chk({tag, "_latency"}, lat, exp_err ? 0 : LANES);
    chk({tag, "_aluFunction_cycles"}, fn_cyc, exp_err ? 0 : LANES);
    chk({tag, "_alu_lane_drive"}, lane_ok, 1);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk({tag, "_resZero"}, zero, exp_data == '0);
`endif
    chk({tag, "_resValid_after_take"}, bus.resValid, 0);
    chk({tag, "_cmdReady_after_take"}, bus.cmdReady, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmdReady"}, bus.cmdReady, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_resValid"}, bus.resValid, 0);
    chk({tag, "_resErr"}, bus.resErr, 0);
    chk({tag, "_resData"}, bus.resData, 0);
    chk({tag, "_aluFunction"}, bus.aluFunction, 0);
    chk({tag, "_aluOpA"}, bus.aluOpA, 0);
    chk({tag, "_aluOpB"}, bus.aluOpB, 0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk({tag, "_resZero"}, bus.resZero, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] data, held;
    logic        err, zero, lane_ok;
    int          lat, fn_cyc;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    vecs[0]  = '{4'd2,  32'h04030201, 32'h10101010, 32'h14131211, 1'b0};
    vecs[1]  = '{4'd3,  32'h00000000, 32'h00000001, 32'h000000FF, 1'b0};
    vecs[2]  = '{4'd11, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1};
    vecs[3]  = '{4'd5,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0};
    vecs[4]  = '{4'd4,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 1'b0};
    vecs[5]  = '{4'd2,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h4A4A4A4A, 1'b0};
    vecs[6]  = '{4'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[7]  = '{4'd15, 32'h01020304, 32'h05060708, 32'h00000000, 1'b1};
    vecs[8]  = '{4'd1,  32'h11223344, 32'h55667788, 32'h11223344, 1'b0};
    vecs[9]  = '{4'd6,  32'hF0F00F0F, 32'h0F0F0000, 32'hFFFF0F0F, 1'b0};
    vecs[10] = '{4'd10, 32'h00FF00FF, 32'h12345678, 32'hFF00FF00, 1'b0};
    vecs[11] = '{4'd9,  32'h80402010, 32'h00000000, 32'h40201008, 1'b0};
    vecs[12] = '{4'd8,  32'h81422418, 32'h00000000, 32'h02844830, 1'b0};
    vecs[13] = '{4'd7,  32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};

    bus.cmdValid = 1'b0;
    bus.cmdOp    = '0;
    bus.cmdA     = '0;
    bus.cmdB     = '0;
    bus.resReady = 1'b0;
    rst_n        = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_reset_outputs("reset_before_clock");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    @(negedge clk) rst_n = 1'b1;

    // First vector is offered straight after release: accepted on the first edge.
    for (int i = 0; i < NV; i++)
      check_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].data, vecs[i].err);

    for (int i = 0; i < 30; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      check_cmd($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, ref_result(rop, ra, rb), !is_legal(rop));
    end

    // Backpressure: result held for 10 cycles while a second command waits.
    run_cmd(4'd2, 32'h04030201, 32'h10101010, 1'b0, data, err, zero, lat, fn_cyc, lane_ok);
    chk("bp_first_resData", data, 32'h14131211);
    held = data;
    bus.cmdValid = 1'b1;
    bus.cmdOp    = 4'd6;
    bus.cmdA     = 32'h01020408;
    bus.cmdB     = 32'h10204080;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_resValid", c), bus.resValid, 1);
      chk($sformatf("bp_hold%0d_resData", c), bus.resData, held);
      chk($sformatf("bp_hold%0d_cmdReady", c), bus.cmdReady, 0);
    end
    bus.resReady = 1'b1;
    @(posedge clk); #1;
    bus.resReady = 1'b0;
    chk("bp_release_resValid", bus.resValid, 0);
    chk("bp_release_cmdReady", bus.cmdReady, 1);
    @(posedge clk); #1;
    bus.cmdValid = 1'b0;
    chk("bp_second_accept_busy", bus.busy, 1);
    chk("bp_second_accept_cmdReady", bus.cmdReady, 0);
    lat = 0;
    while (!bus.resValid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp_second_latency", lat, LANES);
    chk("bp_second_resData", bus.resData, ref_result(4'd6, 32'h01020408, 32'h10204080));
    bus.resReady = 1'b1;
    @(posedge clk); #1;
    bus.resReady = 1'b0;

    // Reset after lane 1 has been written: nothing from that command survives.
    bus.cmdValid = 1'b1;
    bus.cmdOp    = 4'd2;
    bus.cmdA     = 32'h04030201;
    bus.cmdB     = 32'h10101010;
    @(posedge clk); #1;
    bus.cmdValid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrun_busy_before_reset", bus.busy, 1);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midrun_reset");
    @(posedge clk); #1;
    check_reset_outputs("midrun_reset_clocked");
    @(negedge clk) rst_n = 1'b1;
    check_cmd("after_reset", 4'd5, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
